bpred_update_ctrl: RTL and testbench
====================================

# bpred_update_ctrl

Update scheduler for the branch predictor's 2-bit direction-counter table. It sequences the table's single read/write port between two users. After reset it sweeps every entry to a known value. After that it buffers execute-stage resolved-branch updates in a small FIFO and drains them as serialized read-modify-write operations, holding off new operations while the front end is stalled. It sits between the execute-stage update bus and the counter RAM that feeds fetch-time direction prediction.

## Interface
Parameters:
- IDX_W, 8: table index width; the table has 2^IDX_W entries.
- FIFO_DEPTH, 4: update buffer depth; must be a power of 2 and at least 2.
- CTR_INIT, 2'b01: value written to every entry during the init sweep (weakly not-taken).

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- execute_bpredictor_update  in  1  one resolved conditional branch this cycle. Valid-only: there is no backpressure.
- execute_bpredictor_PC4  in  32  branch PC + 4.
- execute_bpredictor_dir  in  1  resolved direction, 1 = taken.
- soin_bpredictor_stall  in  1  front-end stall; blocks the start of new read-modify-writes.
- tbl_raddr  out  IDX_W  counter RAM read address. The RAM is synchronous with 1-cycle read latency.
- tbl_rdata  in  2  counter RAM read data.
- tbl_wen  out  1  counter RAM write enable.
- tbl_waddr  out  IDX_W  counter RAM write address.
- tbl_wdata  out  2  counter RAM write data.
- init_busy  out  1  high while the init sweep is running.
- upd_overflow  out  1  sticky flag: an update was dropped.
- fifo_count  out  log2(FIFO_DEPTH)+1  number of buffered updates.

## Operation
- Each FIFO entry holds {idx, dir}, with idx = (execute_bpredictor_PC4 − 32'd4)[IDX_W+1:2]. The subtraction is full 32-bit and wraps modulo 2^32.
- FSM states: INIT, IDLE, RD, WR.
  - INIT: drives tbl_wen=1, tbl_waddr=sweep_ctr, tbl_wdata=CTR_INIT, and increments sweep_ctr each cycle. After writing entry 2^IDX_W−1 it moves to IDLE. The sweep ignores soin_bpredictor_stall.
  - IDLE: if fifo_count≠0 and soin_bpredictor_stall=0, pop the FIFO head into the op register, drive tbl_raddr=head.idx, and go to RD. Otherwise stay in IDLE.
  - RD: one-cycle wait for RAM data; go to WR.
  - WR: tbl_wen=1, tbl_waddr=op.idx, tbl_wdata=sat(tbl_rdata, op.dir). Then go to IDLE.
  - Once RD is entered, the operation always completes through WR; a stall arriving mid-operation does not abort it.
- Saturation rule: with dir=1 the new value is min(c+1, 3); with dir=0 it is max(c−1, 0).
- Operations are serialized: at most one read-modify-write is in flight. Back-to-back updates to the same index therefore observe each other's writes with no hazard.
- FIFO behaviour:
  - Pushes are accepted in every state, including INIT.
  - If push and pop happen in the same cycle while the FIFO is full, the push is accepted and the count is unchanged.
  - If a push arrives while the FIFO is full and there is no pop, the update is dropped and upd_overflow is set to 1. The flag clears only on reset.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- tbl_raddr may hold any value outside IDLE-pop cycles. tbl_wen=0 in IDLE and RD.

## Timing
- Reset values (in the cycle reset is sampled high and on all following reset-high cycles):
  - state=INIT, sweep_ctr=0, FIFO empty, fifo_count=0, upd_overflow=0.
  - init_busy=1, tbl_wen=0 (gated by reset), tbl_waddr=0, tbl_wdata=CTR_INIT, tbl_raddr=0.
- Sweep timing: the first cycle after reset deasserts writes address 0. Address 2^IDX_W−1 is written in cycle 2^IDX_W. init_busy falls in cycle 2^IDX_W+1, the same cycle the FSM is in IDLE.
- Reset asserted mid-sweep or mid-operation aborts everything, clears the FIFO, and restarts the sweep from 0. An in-progress WR is not performed.
- Update latency, for an empty FIFO in IDLE with no stall:
  - push sampled in cycle t;
  - pop and tbl_raddr in cycle t+1;
  - RD in cycle t+2;
  - write in cycle t+3.
- Throughput: one update every 3 cycles (IDLE, RD, WR).
- fifo_count updates in the cycle after the push or pop edge.

## Test plan
- Init sweep, with IDX_W=8 and CTR_INIT=01: release reset. Expect exactly 256 writes to addresses 0..255 with data 01, init_busy=0 from cycle 257, and no writes afterwards while updates are idle.
- Single update, PC4=0x0000_0108, dir=1, RAM entry 0x41=01: expect tbl_raddr=0x41 at t+1 and a write of 0x41←10 at t+3.
- Saturation: with entry=11, send dir=1 and expect a write of 11. With entry=00, send dir=0 and expect a write of 00.
- Buffering during init: push 3 updates while init_busy=1. Expect fifo_count=3, no table reads before the sweep ends, then 3 serialized read-modify-writes in FIFO order.
- Overflow and stall: hold soin_bpredictor_stall=1 and push 5 updates (FIFO_DEPTH=4). Expect fifo_count=4, upd_overflow=1, and the 5th update never written. After the stall is released, 4 writes occur. A stall raised during RD still lets that operation's WR occur.
- Same-index chain and reset: 3 dir=1 updates to one index starting from 00 yield writes 01, 10, 11. Reset asserted in a WR cycle gives tbl_wen=0 that cycle, fifo_count=0, and the sweep restarting at address 0.

Source files
------------

// File: rtl/bpred_update_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | bpred_update_ctrl                                                        |
// | Init sweep plus buffered, serialized read-modify-write of 2-bit counters |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bpred_update_ctrl #(
  parameter int         IDX_W      = 8,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] CTR_INIT   = 2'b01
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          execute_bpredictor_update,
  input  logic [31:0]                   execute_bpredictor_PC4,
  input  logic                          execute_bpredictor_dir,
  input  logic                          soin_bpredictor_stall,
  output logic [IDX_W-1:0]              tbl_raddr,
  input  logic [1:0]                    tbl_rdata,
  output logic                          tbl_wen,
  output logic [IDX_W-1:0]              tbl_waddr,
  output logic [1:0]                    tbl_wdata,
  output logic                          init_busy,
  output logic                          upd_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RD   = 2'd2,
    ST_WR   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   sweep_q, sweep_d;
  logic [IDX_W-1:0]   op_idx_q, op_idx_d;
  logic               op_dir_q, op_dir_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]   mem_d [FIFO_DEPTH];

  logic [31:0]        pc_m4;
  logic [IDX_W-1:0]   push_idx;
  logic               unused_pc_bits;
  logic [ENT_W-1:0]   head;
  logic               pop;
  logic               push_ok;
  logic               full;

  // Index comes from the branch PC itself, so undo the +4 with a wrapping subtract.
  assign pc_m4          = execute_bpredictor_PC4 - 32'd4;
  assign push_idx       = pc_m4[IDX_W+1:2];
  assign unused_pc_bits = ^{pc_m4[31:IDX_W+2], pc_m4[1:0]};

  assign head         = mem_q[rd_ptr_q];
  assign full         = (count_q == FULL_CNT);
  assign fifo_count   = count_q;
  assign upd_overflow = ovf_q;

  function automatic logic [1:0] sat_update(input logic [1:0] c, input logic up);
    if (up) begin
      return (c == 2'b11) ? c : c + 2'd1;
    end
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    op_idx_d  = op_idx_q;
    op_dir_d  = op_dir_q;
    pop       = 1'b0;
    tbl_raddr = op_idx_q;
    tbl_wen   = 1'b0;
    tbl_waddr = op_idx_q;
    tbl_wdata = CTR_INIT;
    init_busy = 1'b0;

    case (state_q)
      ST_INIT: begin
        init_busy = 1'b1;
        tbl_wen   = 1'b1;
        tbl_waddr = sweep_q;
        tbl_wdata = CTR_INIT;
        sweep_d   = sweep_q + 1'b1;
        if (sweep_q == {IDX_W{1'b1}}) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        tbl_raddr = head[ENT_W-1:1];
        if ((count_q != '0) && !soin_bpredictor_stall) begin
          pop      = 1'b1;
          op_idx_d = head[ENT_W-1:1];
          op_dir_d = head[0];
          state_d  = ST_RD;
        end
      end
      ST_RD: begin
        // Keep the address steady so the RAM output still holds this entry in WR.
        tbl_raddr = op_idx_q;
        state_d   = ST_WR;
      end
      ST_WR: begin
        tbl_raddr = op_idx_q;
        tbl_wen   = 1'b1;
        tbl_waddr = op_idx_q;
        tbl_wdata = sat_update(tbl_rdata, op_dir_q);
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    // Reset must suppress a write already in progress this very cycle.
    if (reset) begin
      tbl_raddr = '0;
      tbl_wen   = 1'b0;
      tbl_waddr = '0;
      tbl_wdata = CTR_INIT;
      init_busy = 1'b1;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    push_ok  = execute_bpredictor_update && (!full || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (execute_bpredictor_update && full && !pop);

    if (push_ok) begin
      mem_d[wr_ptr_q] = {push_idx, execute_bpredictor_dir};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_INIT;
      sweep_q  <= '0;
      op_idx_q <= '0;
      op_dir_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      op_idx_q <= op_idx_d;
      op_dir_q <= op_dir_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      mem_q    <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bpred_update_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bpred_update_ctrl                                                     |
// | Scoreboard bench with behavioural counter-table model and RAM model      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_bpred_update_ctrl;

  localparam int         IDX_W  = 8;
  localparam int         DEPTH  = 4;
  localparam int         N      = 1 << IDX_W;
  localparam logic [1:0] INIT_V = 2'b01;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              upd = 1'b0;
  logic [31:0]       pc4 = '0;
  logic              dir = 1'b0;
  logic              stall = 1'b0;
  logic [IDX_W-1:0]  raddr, waddr;
  logic [1:0]        rdata, wdata;
  logic              wen, busy, ovf;
  logic [2:0]        cnt;

  always #5 clk = ~clk;

  bpred_update_ctrl #(
    .IDX_W(IDX_W), .FIFO_DEPTH(DEPTH), .CTR_INIT(INIT_V)
  ) dut (
    .clk(clk), .reset(reset),
    .execute_bpredictor_update(upd), .execute_bpredictor_PC4(pc4),
    .execute_bpredictor_dir(dir), .soin_bpredictor_stall(stall),
    .tbl_raddr(raddr), .tbl_rdata(rdata), .tbl_wen(wen),
    .tbl_waddr(waddr), .tbl_wdata(wdata),
    .init_busy(busy), .upd_overflow(ovf), .fifo_count(cnt)
  );

  // Synchronous counter RAM, one-cycle read latency.
  logic [1:0] ram [N];
  logic [1:0] rdata_q;
  assign rdata = rdata_q;
  always @(posedge clk) begin
    if (wen) ram[waddr] <= wdata;
    rdata_q <= ram[raddr];
  end

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [1:0]       val;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [1:0] model [N];
  int         checks = 0;
  int         passes = 0;
  int         writes_seen = 0;
  int         sweep_seen = 0;
  int         accepted = 0;
  logic       busy_prev = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [1:0] sat_ref(input logic [1:0] c, input logic d);
    int v;
    v = int'(c) + (d ? 1 : -1);
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  function automatic logic [31:0] pc_for(input int idx);
    return 32'(idx) * 32'd4 + 32'd4;
  endfunction

  task automatic init_model();
    for (int i = 0; i < N; i++) model[i] = INIT_V;
  endtask

  task automatic drive(input logic [31:0] p, input logic d, input bit acc);
    logic [IDX_W-1:0] ix;
    logic [1:0]       nv;
    upd = 1'b1;
    pc4 = p;
    dir = d;
    if (acc) begin
      ix = IDX_W'((p - 32'd4) >> 2);
      nv = sat_ref(model[ix], d);
      model[ix] = nv;
      sb.push_back('{idx: ix, val: nv});
      accepted++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    upd = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(sb.size()), 32'd0);
    tick();
  endtask

  // Monitor: every table write is either a sweep write or the next expected RMW.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      sweep_seen = 0;
    end else begin
      if (wen) begin
        if (busy) begin
          check("sweep_addr", 32'(waddr), 32'(sweep_seen));
          check("sweep_data", 32'(wdata), 32'(INIT_V));
          sweep_seen++;
        end else if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", waddr, wdata);
        end else begin
          mon_e = sb.pop_front();
          check("rmw_addr", 32'(waddr), 32'(mon_e.idx));
          check("rmw_data", 32'(wdata), 32'(mon_e.val));
          writes_seen++;
        end
      end
      if (busy_prev && !busy) check("sweep_count", 32'(sweep_seen), 32'(N));
    end
    busy_prev = busy;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] p;

    // Reset values
    init_model();
    repeat (3) tick();
    check("rst_busy",  32'(busy),  32'd1);
    check("rst_wen",   32'(wen),   32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_raddr", 32'(raddr), 32'd0);
    check("rst_wdata", 32'(wdata), 32'(INIT_V));
    check("rst_count", 32'(cnt),   32'd0);
    check("rst_ovf",   32'(ovf),   32'd0);

    // Init sweep timing
    reset = 1'b0;
    repeat (N) @(negedge clk);
    check("busy_last_sweep", 32'(busy),  32'd1);
    check("last_sweep_addr", 32'(waddr), 32'(N - 1));
    @(negedge clk);
    check("busy_after_sweep", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    repeat (20) tick();
    check("idle_wen", 32'(wen), 32'd0);
    check("idle_count", 32'(cnt), 32'd0);

    // Single update latency: PC4=0x108 -> idx 0x41, 01 -> 10
    drive(32'h0000_0108, 1'b1, 1'b1);
    tick();
    @(negedge clk);
    check("lat_raddr_t1", 32'(raddr), 32'h41);
    @(negedge clk);
    check("lat_wen_t2", 32'(wen), 32'd0);
    @(negedge clk);
    check("lat_wen_t3",   32'(wen),   32'd1);
    check("lat_waddr_t3", 32'(waddr), 32'h41);
    check("lat_wdata_t3", 32'(wdata), 32'h2);
    @(posedge clk);
    #1;
    drain("drain_single", 20);

    // Saturation at both ends
    for (int i = 0; i < 3; i++) begin drive(pc_for(8'h10), 1'b1, 1'b1); tick(); end
    for (int i = 0; i < 2; i++) begin drive(pc_for(8'h20), 1'b0, 1'b1); tick(); end
    drain("drain_sat", 60);

    // Same-index chain from 00
    for (int i = 0; i < 2; i++) begin drive(pc_for(8'h55), 1'b0, 1'b1); tick(); end
    for (int i = 0; i < 3; i++) begin drive(pc_for(8'h55), 1'b1, 1'b1); tick(); end
    drain("drain_chain", 60);

    // Stall raised during RD still completes the WR
    drive(pc_for(8'h30), 1'b1, 1'b1);
    tick();
    tick();
    stall = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stall_rd_wen",   32'(wen),   32'd1);
    check("stall_rd_waddr", 32'(waddr), 32'h30);
    @(posedge clk);
    #1;

    // Overflow while stalled: 5th update dropped
    for (int i = 0; i < 5; i++) begin
      drive(pc_for(8'h70 + i), 1'b1, i < DEPTH);
      tick();
    end
    repeat (10) tick();
    check("ovf_count", 32'(cnt), 32'(DEPTH));
    check("ovf_flag",  32'(ovf), 32'd1);
    stall = 1'b0;
    drain("drain_ovf", 60);
    repeat (6) tick();
    check("ovf_sticky", 32'(ovf), 32'd1);
    check("ovf_empty",  32'(cnt), 32'd0);

    // Reset asserted in a WR cycle
    drive(pc_for(8'h66), 1'b1, 1'b1);
    tick();
    tick();
    tick();
    check("wr_before_reset", 32'(wen), 32'd1);
    reset = 1'b1;
    #1;
    check("reset_in_wr_wen", 32'(wen), 32'd0);
    init_model();
    accepted = writes_seen;
    tick();
    check("reset_count", 32'(cnt), 32'd0);
    check("reset_ovf",   32'(ovf), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("resweep_wen",   32'(wen),   32'd1);
    check("resweep_waddr", 32'(waddr), 32'd0);
    @(posedge clk);
    #1;

    // Buffering during the sweep
    for (int i = 0; i < 3; i++) begin
      drive(pc_for(int'($urandom_range(0, N - 1))), 1'($urandom_range(0, 1)), 1'b1);
      tick();
    end
    check("init_buf_count", 32'(cnt),  32'd3);
    check("init_buf_busy",  32'(busy), 32'd1);
    n = 0;
    while (busy && n < 300) begin tick(); n++; end
    check("resweep_done", 32'(busy), 32'd0);
    drain("drain_init_buf", 30);

    // Randomized traffic with random stalls
    for (int i = 0; i < 600; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      if ((accepted - writes_seen) < DEPTH && $urandom_range(0, 1) == 1) begin
        p = $urandom;
        if ($urandom_range(0, 7) == 0) p = 32'($urandom_range(0, 3));
        drive(p, 1'($urandom_range(0, 1)), 1'b1);
      end
      tick();
    end
    stall = 1'b0;
    drain("drain_random", 200);
    check("random_ovf", 32'(ovf), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
